// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, drives the synchronous imem and holds the IF/ID register.
// Optional macro FETCH_MISALIGN_TRAP_EN turns misaligned redirect targets into a fault that halts fetch.
module fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_hold,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_imem_ren,
    output logic [31:0] o_imem_raddr,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_nxt_pc,
    output logic        o_vld,
    output logic        o_misalign
);

    typedef enum logic [2:0] {ST_RUN, ST_STALL, ST_HALT, ST_TRAP1, ST_TRAP2} state_t;

    state_t      state_q, state_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic        resp_vld_q, resp_vld_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        skid_vld_q, skid_vld_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        vld_q, vld_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] nxt_pc_q, nxt_pc_d;
    logic        misalign_q, misalign_d;
    logic        issue;
    logic [31:0] redirect_tgt;
    logic        redirect_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_tgt = i_redirect_pc;
    assign redirect_bad = |i_redirect_pc[1:0];
`else
    logic unused_redirect_lsb;
    assign redirect_tgt        = {i_redirect_pc[31:2], 2'b00};
    assign redirect_bad        = 1'b0;
    assign unused_redirect_lsb = ^i_redirect_pc[1:0];
`endif

    assign issue        = (state_q == ST_RUN) && !i_hold && !i_rst;
    assign o_imem_ren   = issue;
    assign o_imem_raddr = f_pc_q;
    assign o_vld        = vld_q;
    assign o_inst       = inst_q;
    assign o_pc         = pc_q;
    assign o_nxt_pc     = nxt_pc_q;
    assign o_misalign   = misalign_q;

    always_comb begin
        state_d     = state_q;
        f_pc_d      = f_pc_q;
        resp_vld_d  = 1'b0;
        resp_pc_d   = resp_pc_q;
        skid_vld_d  = skid_vld_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        vld_d       = vld_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        nxt_pc_d    = nxt_pc_q;
        misalign_d  = misalign_q;

        if (issue) begin
            f_pc_d     = f_pc_q + 32'd4;
            resp_vld_d = 1'b1;
            resp_pc_d  = f_pc_q;
        end

        // Redirect beats halt and hold; a halted core ignores redirects until reset.
        if (i_redirect && state_q != ST_HALT) begin
            f_pc_d     = redirect_tgt;
            resp_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            vld_d      = 1'b0;
            inst_d     = NOP_INST;
            misalign_d = 1'b0;
            state_d    = redirect_bad ? ST_TRAP1 : ST_RUN;
        end else if (i_halt) begin
            f_pc_d     = f_pc_q;
            resp_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            vld_d      = 1'b0;
            inst_d     = NOP_INST;
            misalign_d = 1'b0;
            state_d    = ST_HALT;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (i_hold) begin
                        state_d = ST_STALL;
                        if (resp_vld_q) begin
                            skid_vld_d  = 1'b1;
                            skid_inst_d = i_imem_rdata;
                            skid_pc_d   = resp_pc_q;
                        end
                    end else if (skid_vld_q) begin
                        vld_d      = 1'b1;
                        inst_d     = skid_inst_q;
                        pc_d       = skid_pc_q;
                        nxt_pc_d   = skid_pc_q + 32'd4;
                        misalign_d = 1'b0;
                        skid_vld_d = 1'b0;
                    end else begin
                        vld_d      = resp_vld_q;
                        inst_d     = resp_vld_q ? i_imem_rdata : NOP_INST;
                        pc_d       = resp_pc_q;
                        nxt_pc_d   = resp_pc_q + 32'd4;
                        misalign_d = 1'b0;
                    end
                end
                ST_STALL: begin
                    // The response that arrived while decode stalled sits in the skid.
                    if (!i_hold) begin
                        state_d    = ST_RUN;
                        skid_vld_d = 1'b0;
                        if (skid_vld_q) begin
                            vld_d      = 1'b1;
                            inst_d     = skid_inst_q;
                            pc_d       = skid_pc_q;
                            nxt_pc_d   = skid_pc_q + 32'd4;
                            misalign_d = 1'b0;
                        end else begin
                            vld_d  = 1'b0;
                            inst_d = NOP_INST;
                        end
                    end
                end
                ST_HALT: begin
                    vld_d      = 1'b0;
                    inst_d     = NOP_INST;
                    misalign_d = 1'b0;
                    skid_vld_d = 1'b0;
                end
                ST_TRAP1: begin
                    state_d = ST_TRAP2;
                end
                ST_TRAP2: begin
                    vld_d      = 1'b1;
                    inst_d     = NOP_INST;
                    pc_d       = f_pc_q;
                    nxt_pc_d   = f_pc_q + 32'd4;
                    misalign_d = 1'b1;
                    state_d    = ST_HALT;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            f_pc_q      <= RESET_ADDR;
            resp_vld_q  <= 1'b0;
            resp_pc_q   <= 32'd0;
            skid_vld_q  <= 1'b0;
            skid_inst_q <= 32'd0;
            skid_pc_q   <= 32'd0;
            vld_q       <= 1'b0;
            inst_q      <= NOP_INST;
            pc_q        <= 32'd0;
            nxt_pc_q    <= 32'd0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            f_pc_q      <= f_pc_d;
            resp_vld_q  <= resp_vld_d;
            resp_pc_q   <= resp_pc_d;
            skid_vld_q  <= skid_vld_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            vld_q       <= vld_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            nxt_pc_q    <= nxt_pc_d;
            misalign_q  <= misalign_d;
        end
    end

endmodule
